// File: rtl/uart_rx_pkg.sv
// Shared UART constants and receiver state type.
// Default line rate and clock, frame format (8 data bits, 1 stop bit).
package uart_rx_pkg;

   localparam int DEFAULT_BAUD = 9600;
   localparam int DEFAULT_F    = 50_000_000;
   localparam int DATA_BITS    = 8;
   localparam int STOP_BITS    = 1;

   typedef enum logic [2:0] {
      S_WAIT_HIGH,
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops reset to RST_VAL so the output is clean out of reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a F/BAUD divider, byte strobe on
// valid, stop-bit errors on frame_err.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_WAIT_HIGH | after reset or framing error; wait for line idle (high)
// S_IDLE      | line idle, waiting for a falling edge
// S_START     | count to mid start bit, confirm low or reject as glitch
// S_DATA      | sample 8 data bits LSB first, one per bit period
// S_STOP      | sample stop bit; good -> strobe valid, bad -> frame_err
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int BAUD = DEFAULT_BAUD,
   parameter int F    = DEFAULT_F
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int DIV  = F / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);
   localparam int IW   = $clog2(DATA_BITS);

   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_t            state;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [DATA_BITS-1:0] shreg;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_WAIT_HIGH;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         cnt       <= cnt + CW'(1);
         case (state)
            S_WAIT_HIGH: begin
               cnt <= '0;
               if (rx_s) state <= S_IDLE;
            end
            S_IDLE: begin
               cnt <= '0;
               if (!rx_s) begin
                  state <= S_START;
                  busy  <= 1'b1;
               end
            end
            S_START: begin
               if (cnt == CNT_HALF) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state <= S_DATA;
                     idx   <= '0;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            S_DATA: begin
               if (cnt == CNT_FULL) begin
                  cnt        <= '0;
                  shreg[idx] <= rx_s;
                  idx        <= idx + IW'(1);
                  if (idx == IDX_LAST) state <= S_STOP;
               end
            end
            S_STOP: begin
               // Leave at mid-stop so a start bit right after the stop bit is caught.
               if (cnt == CNT_FULL) begin
                  cnt  <= '0;
                  busy <= 1'b0;
                  if (rx_s) begin
                     data  <= shreg;
                     valid <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= S_WAIT_HIGH;
                  end
               end
            end
            default: begin
               state <= S_WAIT_HIGH;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at F=1600, BAUD=100 (16 clocks per bit).
// Stimulus pushes expected strobes; a negedge monitor pops and compares.
module tb_uart_rx;

   localparam int F      = 1600;
   localparam int BAUD   = 100;
   localparam int CLK_T  = 100;
   localparam int BIT_T  = CLK_T * (F / BAUD);
   localparam int LAT    = 155;

   typedef struct {
      logic       is_err;
      logic [7:0] b;
      int         fall;
      int         lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   exp_t       exp_q[$];
   logic [7:0] model_data = 8'h00;
   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   logic       prev_strobe = 1'b0;
   int         last_valid_cyc = 0;
   int         prev_valid_cyc = 0;

   uart_rx #(
      .BAUD (BAUD),
      .F    (F)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #(CLK_T / 2) clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (valid || frame_err)) begin
         chk("strobe_exclusive", {31'd0, valid & frame_err}, 32'd0);
         chk("strobe_not_consecutive", {31'd0, prev_strobe}, 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", {31'd0, valid}, 32'd2);
         end else begin
            e = exp_q.pop_front();
            chk("strobe_kind_ferr", {31'd0, frame_err}, {31'd0, e.is_err});
            if (valid) begin
               chk("data_byte", {24'd0, data}, {24'd0, e.b});
               model_data = e.b;
               prev_valid_cyc = last_valid_cyc;
               last_valid_cyc = cyc;
            end else begin
               chk("ferr_data_hold", {24'd0, data}, {24'd0, model_data});
            end
            if (e.lat >= 0) chk("strobe_latency", cyc - e.fall, e.lat);
         end
      end
      prev_strobe = !rst && (valid || frame_err);
   end

   // Drives one frame; call on a negedge. rst_at >= 0 pulses rst mid data bit rst_at.
   task automatic send(input logic [7:0] b, input logic stop, input int bit_t, input int rst_at);
      exp_t e;
      if (rst_at < 0) begin
         e.is_err = !stop;
         e.b      = b;
         e.fall   = cyc;
         e.lat    = (bit_t == BIT_T) ? LAT : -1;
         exp_q.push_back(e);
      end
      rx = 1'b0;
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (i == rst_at) begin
            repeat (8) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            model_data = 8'h00;
            chk("rst_data", {24'd0, data}, 32'd0);
            chk("rst_valid", {31'd0, valid}, 32'd0);
            chk("rst_ferr", {31'd0, frame_err}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            repeat (7) @(negedge clk);
         end else begin
            #(bit_t);
         end
      end
      rx = stop;
      #(bit_t);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      @(negedge clk);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input int max_cycles);
      int waited = 0;
      while (exp_q.size() != 0 && waited < max_cycles) begin
         @(negedge clk);
         waited++;
      end
      chk("drain_queue_empty", exp_q.size(), 32'd0);
      exp_q.delete();
      repeat (20) @(negedge clk);
   endtask

   initial begin
      logic seen;
      int   g;
      logic [7:0] rb;
      logic rstop;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_data", {24'd0, data}, 32'd0);
      chk("reset_valid", {31'd0, valid}, 32'd0);
      chk("reset_ferr", {31'd0, frame_err}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      idle(5);

      send(8'hA5, 1'b1, BIT_T, -1);
      idle(20);
      drain(400);

      send(8'h00, 1'b1, BIT_T, -1);
      send(8'hFF, 1'b1, BIT_T, -1);
      idle(20);
      drain(400);
      chk("back_to_back_gap", last_valid_cyc - prev_valid_cyc, 32'd160);

      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      seen = 1'b0;
      repeat (9) begin
         @(negedge clk);
         seen = seen | busy;
      end
      chk("glitch_busy_pulse", {31'd0, seen}, 32'd1);
      chk("glitch_busy_drop", {31'd0, busy}, 32'd0);
      idle(10);
      send(8'h3C, 1'b1, BIT_T, -1);
      idle(20);
      drain(400);

      send(8'h3C, 1'b0, BIT_T, -1);
      rx = 1'b0;
      repeat (50) @(negedge clk);
      chk("low_hold_busy", {31'd0, busy}, 32'd0);
      idle(20);
      send(8'h81, 1'b1, BIT_T, -1);
      idle(20);
      drain(400);

      send(8'hE7, 1'b1, BIT_T, 4);
      idle(20);
      chk("rst_frame_data", {24'd0, data}, 32'd0);
      send(8'h5A, 1'b1, BIT_T, -1);
      idle(20);
      drain(400);

      // Sender running 3% slow and 3% fast, inside the receiver's rate tolerance.
      send(8'h55, 1'b1, BIT_T * 97 / 100, -1);
      idle(20);
      send(8'hAA, 1'b1, BIT_T * 97 / 100, -1);
      idle(20);
      send(8'h55, 1'b1, BIT_T * 103 / 100, -1);
      idle(20);
      send(8'hAA, 1'b1, BIT_T * 103 / 100, -1);
      idle(20);
      drain(400);

      for (int n = 0; n < 16; n++) begin
         rb    = 8'($urandom_range(0, 255));
         rstop = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 3) == 0) begin
            g  = $urandom_range(1, 5);
            rx = 1'b0;
            repeat (g) @(negedge clk);
            idle(12);
         end
         send(rb, rstop, BIT_T, -1);
         if (!rstop) idle($urandom_range(20, 40));
         else if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 30));
      end
      idle(20);
      drain(3000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #(CLK_T * 60000);
      $display("FAIL watchdog: simulation exceeded 60000 cycles");
      $fatal(1, "watchdog");
   end

endmodule
